// File: rtl/alu_pipe.sv
// Parametrised sequential ALU with valid/ready handshakes, iterative shifter and accumulator.
// Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags output.
module alu_pipe #(
    parameter int WIDTH = 6,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] acc
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

`ifdef ALU_FLAGS_EN
    localparam int SUMW = WIDTH + 1;
`else
    localparam int SUMW = WIDTH;
`endif

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_count;
    logic             r_left;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH-1:0] w_opA;
    logic [SHW-1:0]   w_count;
    logic             w_isShiftOp;
    logic             w_startShift;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_yop;
    logic             w_isSub;
    logic [SUMW-1:0]  w_sum;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_shiftNext;

    assign w_opA        = use_acc ? r_acc : a;
    assign w_count      = b[SHW-1:0];
    assign w_isShiftOp  = (op == 4'hC) || (op == 4'hD);
    assign w_startShift = w_isShiftOp && (w_count != '0);
    assign w_shiftNext  = r_left ? {r_work[WIDTH-2:0], 1'b0} : {1'b0, r_work[WIDTH-1:1]};

    // Ops 2..7 share one adder/subtractor; the extra sum bit is the carry/borrow.
    always_comb begin
        w_x     = w_opA;
        w_yop   = b;
        w_isSub = 1'b0;
        case (op)
            4'h2: w_yop = WIDTH'(1);
            4'h3: begin w_x = b; w_yop = WIDTH'(1); end
            4'h4: begin w_yop = WIDTH'(1); w_isSub = 1'b1; end
            4'h5: begin w_x = b; w_yop = WIDTH'(1); w_isSub = 1'b1; end
            4'h7: w_isSub = 1'b1;
            default: ;
        endcase
        w_sum = w_isSub ? (SUMW'(w_x) - SUMW'(w_yop)) : (SUMW'(w_x) + SUMW'(w_yop));
    end

    always_comb begin
        w_result = w_opA;
        case (op)
            4'h0:    w_result = w_opA;
            4'h1:    w_result = b;
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
                     w_result = w_sum[WIDTH-1:0];
            4'h8:    w_result = w_opA & b;
            4'h9:    w_result = w_opA | b;
            4'hA:    w_result = w_opA ^ b;
            4'hB:    w_result = ~w_opA;
            4'hE:    w_result = (w_opA > b) ? w_opA : b;
            4'hF:    w_result = (w_opA < b) ? w_opA : b;
            default: w_result = w_opA;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = w_startShift ? SHIFT : HOLD;
            SHIFT:   if (r_count == SHW'(1)) w_nextState = HOLD;
            HOLD:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work  <= '0;
            r_count <= '0;
            r_left  <= 1'b0;
            r_y     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_startShift) begin
                            r_work  <= w_opA;
                            r_count <= w_count;
                            r_left  <= (op == 4'hC);
                        end else begin
                            r_y <= w_result;
                        end
                    end
                end
                SHIFT: begin
                    r_work  <= w_shiftNext;
                    r_count <= r_count - SHW'(1);
                    if (r_count == SHW'(1)) r_y <= w_shiftNext;
                end
                HOLD: begin
                    if (out_ready) r_acc <= r_y;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] r_flags;
    logic       w_arith;
    logic       w_carry;
    logic       w_ovf;
    logic       w_shiftOut;

    assign w_arith    = (op >= 4'h2) && (op <= 4'h7);
    assign w_carry    = w_arith & w_sum[WIDTH];
    assign w_ovf      = w_arith & (w_isSub ? (w_x[WIDTH-1] != w_yop[WIDTH-1])
                                           : (w_x[WIDTH-1] == w_yop[WIDTH-1]))
                                & (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    assign w_shiftOut = r_left ? r_work[WIDTH-1] : r_work[0];

    // Flags are captured on the same edges that load r_y so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
        end else if (r_state == IDLE && in_valid && !w_startShift) begin
            r_flags <= {w_result[WIDTH-1], (w_result == '0), w_carry, w_ovf};
        end else if (r_state == SHIFT && r_count == SHW'(1)) begin
            r_flags <= {w_shiftNext[WIDTH-1], (w_shiftNext == '0), w_shiftOut, 1'b0};
        end
    end

    assign flags = r_flags;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign y         = r_y;
    assign acc       = r_acc;

endmodule
